// File: rtl/mux_channel_scheduler.sv
// Three single-word channel buffers (alpha/beta/gamma) with round-robin arbitration
// that drives a 3:1 mux from registers. Optional handshake counters: MUX_SCHED_STATS_EN.
module mux_channel_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  input  logic             g_valid,
  input  logic [WIDTH-1:0] g_data,
  output logic             g_ready,
  output logic [1:0]       sel,
  output logic             cs,
  output logic [WIDTH-1:0] alpha,
  output logic [WIDTH-1:0] beta,
  output logic [WIDTH-1:0] gamma,
  output logic             out_valid,
  input  logic             out_ready
`ifdef MUX_SCHED_STATS_EN
  ,
  output logic [15:0]      cnt_a,
  output logic [15:0]      cnt_b,
  output logic [15:0]      cnt_g
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_G = 2'd2;

  state_t     state;
  logic [2:0] full;        // bit order {gamma, beta, alpha}
  logic [1:0] last_grant;
  logic [2:0] accept;
  logic [2:0] drain;
  logic [2:0] pending;
  logic       handshake;
  logic [1:0] idle_winner;
  logic [1:0] b2b_winner;

  // First requesting channel strictly after 'last', in order 0,1,2 wrapping.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    // NOTE: blocking '=' is right for function/combinational temporaries;
    // every register in this file is updated with '<=' in always_ff.
    rr_pick = CH_A;
    found   = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      idx = 2'((int'(last) + k) % 3);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign a_ready   = ~full[0];
  assign b_ready   = ~full[1];
  assign g_ready   = ~full[2];
  assign out_valid = cs;

  assign accept    = {g_valid & ~full[2], b_valid & ~full[1], a_valid & ~full[0]};
  assign handshake = (state == GRANT) && out_ready;

  always_comb begin
    // NOTE: default first so the conditional bit write cannot infer a latch.
    drain = 3'b000;
    if (handshake) drain[sel] = 1'b1;
  end

  // The drained channel counts as empty; same-cycle accepts are not yet in 'full'.
  assign pending     = full & ~drain;
  assign idle_winner = rr_pick(full, last_grant);
  assign b2b_winner  = rr_pick(pending, sel);

  // NOTE: the buffers are only three words, so they are reset like any other
  // register; a reset therefore drops every stored word along with its flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full  <= 3'b000;
      alpha <= '0;
      beta  <= '0;
      gamma <= '0;
    end else begin
      full <= pending | accept;
      if (accept[0]) alpha <= a_data;
      if (accept[1]) beta  <= b_data;
      if (accept[2]) gamma <= g_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= CH_A;
      cs         <= 1'b0;
      last_grant <= CH_G;
    end else begin
      case (state)
        IDLE: begin
          if (|full) begin
            sel   <= idle_winner;
            cs    <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (out_ready) begin
            last_grant <= sel;
            if (|pending) begin
              sel <= b2b_winner;
            end else begin
              cs    <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          cs    <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MUX_SCHED_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= '0;
      cnt_b <= '0;
      cnt_g <= '0;
    end else begin
      if (drain[0]) cnt_a <= sat_inc(cnt_a);
      if (drain[1]) cnt_b <= sat_inc(cnt_b);
      if (drain[2]) cnt_g <= sat_inc(cnt_g);
    end
  end
`endif

endmodule
